// File: rtl/adv7513_i2c_sched.sv
// Sequencer and bus owner for the shared ADV7513 I2C pads: starts and retries
// the init engine, then periodically launches register reads.
module adv7513_i2c_sched #(
    parameter int unsigned POLL_CYCLES    = 12500000,
    parameter int unsigned MIN_GAP        = 8,
    parameter int unsigned TIMEOUT_CYCLES = 2500000,
    parameter int unsigned CNT_W          = 24
) (
    input  logic       clk,
    input  logic       reset,
    output logic       init_start,
    input  logic       init_done,
    input  logic       init_scl_oe,
    input  logic       init_sda_oe,
    output logic       rd_start,
    input  logic       rd_done,
    input  logic       rd_scl_oe,
    input  logic       rd_sda_oe,
    input  logic [7:0] reg_addr,
    output logic [7:0] rd_addr,
    output logic       scl_oe,
    output logic       sda_oe,
    output logic [1:0] owner,
    output logic       init_ok,
    output logic       rd_update,
    output logic       timeout_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT_GO,
        S_INIT_RUN,
        S_GAP,
        S_RD_GO,
        S_RD_RUN
    } state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_INIT = 2'b01;
    localparam logic [1:0] OWN_RD   = 2'b10;

    localparam logic [CNT_W-1:0] POLL_LAST = CNT_W'(POLL_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(MIN_GAP - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             init_done_q, rd_done_q;
    logic             init_start_q, init_start_d;
    logic             rd_start_q, rd_start_d;
    logic             rd_update_q, rd_update_d;
    logic             init_ok_q, init_ok_d;
    logic             timeout_err_q, timeout_err_d;
    logic             busy_q, busy_d;
    logic [1:0]       owner_q, owner_d;
    logic [7:0]       rd_addr_q, rd_addr_d;

    logic init_edge, rd_edge, cnt_tmo, gap_exit;

    always_comb begin
        init_edge = init_done & ~init_done_q;
        rd_edge   = rd_done & ~rd_done_q;
        cnt_tmo   = (cnt_q == TMO_LAST);
        // a changed address only shortens the gap once init is known good
        gap_exit  = (cnt_q == POLL_LAST) ||
                    (init_ok_q && (reg_addr != rd_addr_q) && (cnt_q >= GAP_LAST));

        state_d       = state_q;
        init_ok_d     = init_ok_q;
        timeout_err_d = timeout_err_q;
        rd_addr_d     = rd_addr_q;
        rd_update_d   = 1'b0;

        case (state_q)
            S_IDLE:    state_d = S_INIT_GO;
            S_INIT_GO: state_d = S_INIT_RUN;
            S_INIT_RUN: begin
                if (init_edge) begin
                    init_ok_d = 1'b1;
                    state_d   = S_GAP;
                end else if (cnt_tmo) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_exit) begin
                    state_d = init_ok_q ? S_RD_GO : S_INIT_GO;
                end
            end
            S_RD_GO:   state_d = S_RD_RUN;
            S_RD_RUN: begin
                if (rd_edge) begin
                    rd_update_d = 1'b1;
                    state_d     = S_GAP;
                end else if (cnt_tmo) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_GAP;
                end
            end
            default:   state_d = S_IDLE;
        endcase

        if (state_d == S_INIT_GO) begin
            init_ok_d = 1'b0;
        end
        if (state_d == S_RD_GO) begin
            rd_addr_d = reg_addr;
        end

        // one counter serves both the gap length and the run timeout
        cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

        init_start_d = (state_d == S_INIT_GO);
        rd_start_d   = (state_d == S_RD_GO);
        busy_d       = (state_d == S_INIT_RUN) || (state_d == S_RD_RUN);

        owner_d = OWN_NONE;
        case (state_d)
            S_INIT_GO, S_INIT_RUN: owner_d = OWN_INIT;
            S_RD_GO, S_RD_RUN:     owner_d = OWN_RD;
            default:               owner_d = OWN_NONE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            init_done_q   <= 1'b0;
            rd_done_q     <= 1'b0;
            init_start_q  <= 1'b0;
            rd_start_q    <= 1'b0;
            rd_update_q   <= 1'b0;
            init_ok_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            owner_q       <= OWN_NONE;
            rd_addr_q     <= 8'h00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            init_done_q   <= init_done;
            rd_done_q     <= rd_done;
            init_start_q  <= init_start_d;
            rd_start_q    <= rd_start_d;
            rd_update_q   <= rd_update_d;
            init_ok_q     <= init_ok_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            owner_q       <= owner_d;
            rd_addr_q     <= rd_addr_d;
        end
    end

    assign init_start  = init_start_q;
    assign rd_start    = rd_start_q;
    assign rd_update   = rd_update_q;
    assign init_ok     = init_ok_q;
    assign timeout_err = timeout_err_q;
    assign busy        = busy_q;
    assign owner       = owner_q;
    assign rd_addr     = rd_addr_q;

    // only the current owner's drive-low requests reach the pads
    assign scl_oe = ((owner_q == OWN_INIT) && init_scl_oe) || ((owner_q == OWN_RD) && rd_scl_oe);
    assign sda_oe = ((owner_q == OWN_INIT) && init_sda_oe) || ((owner_q == OWN_RD) && rd_sda_oe);

endmodule

// File: doc/adv7513_i2c_sched.md
# adv7513_i2c_sched

Sequencer and bus owner for the shared ADV7513 I2C pads. It starts the `adv7513_init` engine after reset and retries it on timeout. Once init completes, it periodically launches `adv7513_reg_read` on the selected register address. At any time it passes exactly one engine's open-drain drive-low enables to `I2C_SCL`/`I2C_SDA`, which removes the two-driver contention on the bus.

## Interface

- `POLL_CYCLES`, 12500000: gap length between read polls, in `clk` cycles (100 ms at 125 MHz).
- `MIN_GAP`, 8: minimum idle cycles between any two transactions.
- `TIMEOUT_CYCLES`, 2500000: maximum run time of one transaction before it is abandoned.
- `CNT_W`, 24: width of the gap and timeout counters; must hold `POLL_CYCLES` and `TIMEOUT_CYCLES`.
- `clk`  in  1  system clock (the inverted 125 MHz pixel clock).
- `reset`  in  1  asynchronous, active-high reset.
- `init_start`  out  1  one-cycle start pulse to the init engine.
- `init_done`  in  1  init engine done (level).
- `init_scl_oe`, `init_sda_oe`  in  1 each  init engine drive-low requests.
- `rd_start`  out  1  one-cycle start pulse to the reg-read engine.
- `rd_done`  in  1  reg-read engine done (level).
- `rd_scl_oe`, `rd_sda_oe`  in  1 each  reg-read engine drive-low requests.
- `reg_addr`  in  8  requested register address (switches).
- `rd_addr`  out  8  address latched for the current or last read; drives the reader's `reg_addr`.
- `scl_oe`, `sda_oe`  out  1 each  pad drive-low enables; the pad drives 0 when high and is Z otherwise.
- `owner`  out  2  bus owner: 00 none, 01 init, 10 read.
- `init_ok`  out  1  init has completed successfully.
- `rd_update`  out  1  one-cycle pulse when a read completes; `reg_data` is valid.
- `timeout_err`  out  1  sticky; set on any timeout.
- `busy`  out  1  high in `INIT_RUN` and `RD_RUN`.

## Operation

- States: `IDLE`, `INIT_GO`, `INIT_RUN`, `GAP`, `RD_GO`, `RD_RUN`.
- Done edges: `done_q` registers each done input every cycle. An edge is `done & ~done_q`. Edges are acted on only in the matching `*_RUN` state and are ignored elsewhere.
- `IDLE` → `INIT_GO` on the first clock after reset deasserts.
- `INIT_GO` (1 cycle): `init_start`=1, `owner`=01, `init_ok`=0 → `INIT_RUN`.
- `INIT_RUN`:
  - On an `init_done` edge: `init_ok`=1 → `GAP`.
  - On timeout (counter reaches `TIMEOUT_CYCLES-1`): `timeout_err`=1 → `GAP`.
- `GAP`:
  - `owner`=00; the gap counter is cleared on entry.
  - Exit when the counter reaches `POLL_CYCLES-1`, or early when `init_ok` && `reg_addr`≠`rd_addr` && counter ≥ `MIN_GAP-1`.
  - Exit goes to `RD_GO` if `init_ok`, else to `INIT_GO` (retry).
- `RD_GO` (1 cycle): `rd_addr`←`reg_addr`, `rd_start`=1, `owner`=10 → `RD_RUN`.
- `RD_RUN`:
  - On an `rd_done` edge: `rd_update`=1 for one cycle → `GAP`.
  - On timeout: `timeout_err`=1 → `GAP`; `init_ok` is unchanged.
- If a done edge and the timeout fall in the same cycle, the edge wins; `timeout_err` is not set.
- Changes to `reg_addr` during `RD_RUN` are not applied until the next `GAP` decision.
- Pad mux (combinational from the registered `owner`):
  - `scl_oe` = (`owner`==01 & `init_scl_oe`) | (`owner`==10 & `rd_scl_oe`).
  - `sda_oe` is formed the same way.
  - The non-owner's enables never reach the pads.
- `timeout_err` is cleared only by reset.

## Timing

- Reset (asynchronous) forces:
  - state `IDLE`;
  - `owner`=00, `init_start`=0, `rd_start`=0, `rd_update`=0;
  - `init_ok`=0, `timeout_err`=0, `busy`=0;
  - `rd_addr`=8'h00, counters=0, `done_q`=0;
  - therefore `scl_oe`=`sda_oe`=0 (bus released).
- `init_start` is high for exactly the second cycle after reset release.
- All outputs except `scl_oe` and `sda_oe` are registered. The pad enables add zero latency from the engine enables.
- The bus is unowned for at least `MIN_GAP` cycles between any two transactions.
- Timeout is counted from the cycle after `*_GO`. A done edge at cycle N moves the block to `GAP` at N+1, with `rd_update` high in cycle N+1.
- Reset asserted mid-transaction releases the pads in the same cycle (asynchronous). The sequence then restarts from `INIT_GO`.

## Test plan

Bench parameters: `POLL_CYCLES`=64, `MIN_GAP`=8, `TIMEOUT_CYCLES`=32.

- Reset release, init model raises `init_done` 20 cycles after `init_start` → one `init_start` pulse at cycle 2; `owner`=01 until the edge; `init_ok`=1; `owner`=00 for 64 cycles; then one `rd_start` with `rd_addr`=`reg_addr`.
- Read model raises `rd_done` 10 cycles after each start, `reg_addr` held at 8'h42 → `rd_update` pulses every 76±1 cycles; `rd_addr` stays 8'h42.
- `reg_addr` changed to 8'h96 during `RD_RUN` → current read completes; the next `rd_start` follows 8 cycles after the done edge; `rd_addr`=8'h96.
- Init model never raises done → `timeout_err`=1 after 32 cycles; `owner`=00 for 64 cycles; `init_start` pulses again; `rd_start` never pulses.
- Read engine asserts `rd_sda_oe`=1 while `owner`=01 → `sda_oe` follows only `init_sda_oe`.
- `rd_done` edge coincident with the timeout cycle → `rd_update`=1, `timeout_err`=0; reset pulsed mid-`RD_RUN` → `scl_oe`=`sda_oe`=0 immediately, then `init_start` at cycle 2.
